coin_draw_controller: RTL and testbench
=======================================

// Module: coin_draw_controller
// PURPOSE
//  Frame-synchronous responder to the frame counter's plotEN pulse. Each accepted plot request
//  erases the coin sprite at its current position, advances the coin downward by STEP rows and
//  redraws it, one pixel per clock, on a VGA-adapter-style pixel write port. Sits between the
//  frame-rate pulse chain (rate divider -> frame counter) and the VGA adapter.
// PARAMETERS
//  SCREEN_W     160     visible width in pixels
//  SCREEN_H     120     visible height in pixels
//  COIN_SIZE    4       sprite edge in pixels (power of 2; square sprite)
//  STEP         1       rows advanced per accepted request
//  COLOUR_BG    3'b000  erase colour
//  COLOUR_COIN  3'b110  draw colour
//  START_X      78      coin_x after reset
// PORTS
//  clk         in   1  system clock
//  resetn      in   1  asynchronous, active-low reset
//  plot_req    in   1  one-cycle request pulse (frame counter plotEN)
//  spawn       in   1  one-cycle pulse: restart coin at row 0, column spawn_x
//  spawn_x     in   8  spawn column
//  vga_x       out  8  pixel column
//  vga_y       out  7  pixel row
//  vga_colour  out  3  pixel colour
//  vga_plot    out  1  pixel write strobe; x/y/colour valid when high
//  busy        out  1  high in any state other than IDLE
//  done        out  1  one-cycle pulse when the redraw completes
//  missed      out  1  one-cycle pulse (with done) when the coin wrapped past the bottom
//  coin_x      out  8  current sprite left column
//  coin_y      out  7  current sprite top row
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, pending=0, vga_plot=0, done=0, missed=0, busy=0,
//    vga_x/vga_y/vga_colour=0, coin_x=START_X, coin_y=0. Pixel writes stop immediately.
//  - FSM states: IDLE, ERASE, UPDATE, DRAW, DONE. All outputs are registered.
//  - IDLE: a plot_req, or pending=1, moves to ERASE next cycle and clears pending.
//    The scan counter is cleared.
//  - ERASE: N=COIN_SIZE^2 cycles. Pixel k in 0..N-1 is written at x=coin_x+(k%COIN_SIZE),
//    y=coin_y+(k/COIN_SIZE), using COLOUR_BG. Raster order is row-major.
//  - UPDATE (1 cycle, vga_plot=0): if coin_y+STEP > SCREEN_H-COIN_SIZE, set coin_y=0 and
//    flag a wrap. Otherwise coin_y += STEP.
//  - DRAW: N cycles, same scan as ERASE at the new position, using COLOUR_COIN.
//  - DONE (1 cycle): done=1, and missed=1 if the wrap flag is set. Then go to ERASE if
//    pending=1, clearing pending; otherwise go to IDLE.
//  - Latency: plot_req at cycle T gives the first vga_plot at T+1, the ERASE write burst over
//    T+1..T+N, UPDATE at T+N+1, DRAW writes over T+N+2..T+2N+1, and done at T+2N+2.
//    With defaults, done is at T+34.
//  - plot_req while busy: set pending (one deep). Further requests while pending=1 are dropped.
//  - spawn: accepted only in IDLE. It sets coin_y=0 and coin_x=min(spawn_x, SCREEN_W-COIN_SIZE).
//    spawn is ignored when busy. If spawn and plot_req coincide in IDLE, spawn is applied and
//    the request is latched as pending, so ERASE starts the next cycle at the spawned position.
//  - Width rules: x/y sums are computed 1 bit wider, then truncated. The clamp guarantees
//    x <= SCREEN_W-1 and y <= SCREEN_H-1 on every written pixel.
//  - vga_plot is never high in IDLE, UPDATE or DONE.
// STRUCTURE
//  - coin_pkg (shared): FSM state encoding, SCREEN_W/H, colour constants, X_W=8, Y_W=7.
//  - Sub-module sprite_scan_counter: clear/enable inputs; outputs col, row and last.
//    last is high when k==N-1. The counter wraps to 0 after last.
//  - The top level holds the FSM, the position registers, the pending flag and the output
//    registers.
// TESTING
//  1. Reset, then plot_req at T -> 16 writes of 3'b000 at (78..81, 0..3) over T+1..T+16,
//     then 16 writes of 3'b110 at (78..81, 1..4) over T+18..T+33, done at T+34, coin_y=1.
//  2. plot_req at T and again at T+5 and T+9 -> exactly one extra redraw. The second ERASE
//     starts at T+35. The third request is dropped and coin_y ends at 2.
//  3. coin_y=116, plot_req -> UPDATE wraps to coin_y=0. DRAW writes rows 0..3; done and
//     missed pulse together.
//  4. spawn with spawn_x=200 in IDLE -> coin_x=156, coin_y=0. spawn during DRAW -> no change.
//  5. spawn and plot_req in the same IDLE cycle -> ERASE at the spawned position starts the
//     next cycle.
//  6. resetn low mid-DRAW (pixel 7) -> vga_plot=0 asynchronously, busy=0, coin_y=0,
//     pending cleared. No write occurs until a new plot_req.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared constants, FSM encoding and pixel payload for the coin sprite drawer.
package coin_pkg;

  localparam int unsigned X_W       = 8;
  localparam int unsigned Y_W       = 7;
  localparam int unsigned COL_W     = 3;
  localparam int unsigned SCREEN_W  = 160;
  localparam int unsigned SCREEN_H  = 120;
  localparam int unsigned COIN_SIZE = 4;
  localparam int unsigned STEP      = 1;
  localparam int unsigned START_X   = 78;
  localparam int unsigned SCAN_W    = $clog2(COIN_SIZE);
  localparam int unsigned K_W       = 2 * SCAN_W;
  localparam int unsigned MAX_X     = SCREEN_W - COIN_SIZE;
  localparam int unsigned MAX_Y     = SCREEN_H - COIN_SIZE;

  localparam logic [COL_W-1:0] COLOUR_BG   = 3'b000;
  localparam logic [COL_W-1:0] COLOUR_COIN = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ERASE  = 3'd1,
    S_UPDATE = 3'd2,
    S_DRAW   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic             plot;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
  } pixel_t;

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major pixel index over a COIN_SIZE x COIN_SIZE sprite; wraps to 0 after the last pixel.
module sprite_scan_counter
  import coin_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  output logic [SCAN_W-1:0] col,
  output logic [SCAN_W-1:0] row,
  output logic              last
);

  logic [K_W-1:0] k;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
    end else if (clear) begin
      k <= '0;
    end else if (enable) begin
      k <= k + K_W'(1);
    end
  end

  assign col  = k[SCAN_W-1:0];
  assign row  = k[K_W-1:SCAN_W];
  assign last = (k == {K_W{1'b1}});

endmodule

// File: rtl/coin_draw_controller.sv
// Per-frame erase / step-down / redraw of the coin sprite on a one-pixel-per-clock write port.
module coin_draw_controller
  import coin_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             plot_req,
  input  logic             spawn,
  input  logic [X_W-1:0]   spawn_x,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [COL_W-1:0] vga_colour,
  output logic             vga_plot,
  output logic             busy,
  output logic             done,
  output logic             missed,
  output logic [X_W-1:0]   coin_x,
  output logic [Y_W-1:0]   coin_y
);

  state_t            state, state_n;
  logic              pending, pending_n;
  logic              wrap, wrap_n;
  logic [X_W-1:0]    coin_x_n;
  logic [Y_W-1:0]    coin_y_n;
  logic              scan_clear, scan_en;
  logic [SCAN_W-1:0] col, row;
  logic              last;
  logic [K_W-1:0]    k_nxt;
  logic [Y_W:0]      y_sum;
  logic [X_W-1:0]    spawn_clamped;
  pixel_t            pix_n, pix_q;
  logic              busy_n, done_n, missed_n;

  sprite_scan_counter u_scan (
    .clk    (clk),
    .rst_n  (resetn),
    .clear  (scan_clear),
    .enable (scan_en),
    .col    (col),
    .row    (row),
    .last   (last)
  );

  assign y_sum         = {1'b0, coin_y} + (Y_W+1)'(STEP);
  assign spawn_clamped = (spawn_x > X_W'(MAX_X)) ? X_W'(MAX_X) : spawn_x;

  // Next state, position and pending flag
  always_comb begin
    state_n    = state;
    pending_n  = pending;
    wrap_n     = wrap;
    coin_x_n   = coin_x;
    coin_y_n   = coin_y;
    scan_clear = 1'b0;
    scan_en    = 1'b0;
    case (state)
      S_IDLE: begin
        scan_clear = 1'b1;
        if (spawn) begin
          coin_x_n = spawn_clamped;
          coin_y_n = '0;
        end
        if (spawn && plot_req) begin
          pending_n = 1'b1;
        end else if (plot_req || pending) begin
          state_n   = S_ERASE;
          pending_n = 1'b0;
        end
      end
      S_ERASE: begin
        scan_en   = 1'b1;
        pending_n = pending | plot_req;
        if (last) state_n = S_UPDATE;
      end
      S_UPDATE: begin
        pending_n = pending | plot_req;
        state_n   = S_DRAW;
        if (y_sum > (Y_W+1)'(MAX_Y)) begin
          coin_y_n = '0;
          wrap_n   = 1'b1;
        end else begin
          coin_y_n = y_sum[Y_W-1:0];
          wrap_n   = 1'b0;
        end
      end
      S_DRAW: begin
        scan_en   = 1'b1;
        pending_n = pending | plot_req;
        if (last) state_n = S_DONE;
      end
      S_DONE: begin
        pending_n = plot_req;
        state_n   = pending ? S_ERASE : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the first write lands one cycle after the request
  always_comb begin
    k_nxt    = (state_n == state) ? ({row, col} + K_W'(1)) : '0;
    pix_n    = '0;
    busy_n   = (state_n != S_IDLE);
    done_n   = (state_n == S_DONE);
    missed_n = (state_n == S_DONE) && wrap;
    if (state_n == S_ERASE || state_n == S_DRAW) begin
      pix_n.plot   = 1'b1;
      pix_n.x      = X_W'({1'b0, coin_x_n} + (X_W+1)'(k_nxt[SCAN_W-1:0]));
      pix_n.y      = Y_W'({1'b0, coin_y_n} + (Y_W+1)'(k_nxt[K_W-1:SCAN_W]));
      pix_n.colour = (state_n == S_DRAW) ? COLOUR_COIN : COLOUR_BG;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      pending <= 1'b0;
      wrap    <= 1'b0;
      coin_x  <= X_W'(START_X);
      coin_y  <= '0;
      pix_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      missed  <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      wrap    <= wrap_n;
      coin_x  <= coin_x_n;
      coin_y  <= coin_y_n;
      pix_q   <= pix_n;
      busy    <= busy_n;
      done    <= done_n;
      missed  <= missed_n;
    end
  end

  assign vga_plot   = pix_q.plot;
  assign vga_x      = pix_q.x;
  assign vga_y      = pix_q.y;
  assign vga_colour = pix_q.colour;

endmodule

// File: tb/tb_coin_draw_controller.sv
// Directed, table-driven bench for coin_draw_controller.
module tb_coin_draw_controller;

  logic       clk;
  logic       resetn;
  logic       plot_req;
  logic       spawn;
  logic [7:0] spawn_x;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;
  logic       missed;
  logic [7:0] coin_x;
  logic [6:0] coin_y;

  int errors = 0;
  int checks = 0;

  coin_draw_controller dut (
    .clk        (clk),
    .resetn     (resetn),
    .plot_req   (plot_req),
    .spawn      (spawn),
    .spawn_x    (spawn_x),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done),
    .missed     (missed),
    .coin_x     (coin_x),
    .coin_y     (coin_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         off;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       pix;
    logic       done;
    logic       missed;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [7:0] sx;
    logic [7:0] exp_x;
  } spawn_vec_t;

  vec_t       tbl[12];
  spawn_vec_t stbl[6];

  function automatic vec_t mk(int off, logic plot, logic [7:0] x, logic [6:0] y,
                              logic [2:0] colour, logic pix, logic dn, logic ms, logic bz);
    vec_t v;
    v.off = off; v.plot = plot; v.x = x; v.y = y; v.colour = colour;
    v.pix = pix; v.done = dn; v.missed = ms; v.busy = bz;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    plot_req = 1'b0;
    spawn    = 1'b0;
    spawn_x  = 8'd0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
  endtask

  // Raise plot_req for the current cycle T; returns sampling cycle T+1
  task automatic pulse_req();
    plot_req = 1'b1;
    tick();
    plot_req = 1'b0;
  endtask

  task automatic redraw();
    bit seen;
    seen = 0;
    pulse_req();
    for (int i = 0; i < 50 && !seen; i++) begin
      if (done) seen = 1;
      else tick();
    end
    if (!seen) chk("redraw_timeout", 0, 1);
    tick();
  endtask

  initial begin
    int c;
    int plots;
    int dones;
    int first_plot2;
    int done2_at;

    tbl[0]  = mk(1,  1'b1, 8'd78, 7'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[1]  = mk(2,  1'b1, 8'd79, 7'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[2]  = mk(4,  1'b1, 8'd81, 7'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[3]  = mk(5,  1'b1, 8'd78, 7'd1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[4]  = mk(16, 1'b1, 8'd81, 7'd3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[5]  = mk(17, 1'b0, 8'd0,  7'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    tbl[6]  = mk(18, 1'b1, 8'd78, 7'd1, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[7]  = mk(21, 1'b1, 8'd81, 7'd1, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[8]  = mk(22, 1'b1, 8'd78, 7'd2, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk(33, 1'b1, 8'd81, 7'd4, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[10] = mk(34, 1'b0, 8'd0,  7'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    tbl[11] = mk(35, 1'b0, 8'd0,  7'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    stbl[0] = '{8'd5,   8'd5};
    stbl[1] = '{8'd156, 8'd156};
    stbl[2] = '{8'd157, 8'd156};
    stbl[3] = '{8'd0,   8'd0};
    stbl[4] = '{8'd255, 8'd156};
    stbl[5] = '{8'd200, 8'd156};

    // Reset values
    do_reset();
    chk("rst_plot",   int'(vga_plot),   0);
    chk("rst_x",      int'(vga_x),      0);
    chk("rst_y",      int'(vga_y),      0);
    chk("rst_colour", int'(vga_colour), 0);
    chk("rst_busy",   int'(busy),       0);
    chk("rst_done",   int'(done),       0);
    chk("rst_missed", int'(missed),     0);
    chk("rst_coin_x", int'(coin_x),     78);
    chk("rst_coin_y", int'(coin_y),     0);

    // Single redraw, table-driven
    pulse_req();
    c = 1;
    plots = int'(vga_plot);
    for (int i = 0; i < 12; i++) begin
      while (c < tbl[i].off) begin
        tick();
        c++;
        plots += int'(vga_plot);
      end
      chk($sformatf("t1_plot_%0d", c), int'(vga_plot), int'(tbl[i].plot));
      if (tbl[i].pix) begin
        chk($sformatf("t1_x_%0d", c),      int'(vga_x),      int'(tbl[i].x));
        chk($sformatf("t1_y_%0d", c),      int'(vga_y),      int'(tbl[i].y));
        chk($sformatf("t1_colour_%0d", c), int'(vga_colour), int'(tbl[i].colour));
      end
      chk($sformatf("t1_done_%0d", c),   int'(done),   int'(tbl[i].done));
      chk($sformatf("t1_missed_%0d", c), int'(missed), int'(tbl[i].missed));
      chk($sformatf("t1_busy_%0d", c),   int'(busy),   int'(tbl[i].busy));
    end
    chk("t1_plot_count", plots, 32);
    chk("t1_coin_y", int'(coin_y), 1);

    // Pending: requests at T, T+5, T+9
    do_reset();
    pulse_req();
    plots = int'(vga_plot);
    dones = 0;
    first_plot2 = -1;
    done2_at = -1;
    for (c = 2; c <= 80; c++) begin
      plot_req = (c == 5 || c == 9);
      tick();
      plot_req = 1'b0;
      plots += int'(vga_plot);
      if (done) begin
        dones++;
        if (dones == 2) done2_at = c;
      end
      if (c == 34) chk("t2_done_T34", int'(done), 1);
      if (c > 34 && vga_plot && first_plot2 < 0) first_plot2 = c;
    end
    chk("t2_second_erase_start", first_plot2, 35);
    chk("t2_done_count", dones, 2);
    chk("t2_second_done", done2_at, 68);
    chk("t2_plot_count", plots, 64);
    chk("t2_coin_y", int'(coin_y), 2);
    chk("t2_idle", int'(busy), 0);

    // Wrap at the bottom
    do_reset();
    for (int i = 0; i < 116; i++) redraw();
    chk("t3_coin_y_116", int'(coin_y), 116);
    pulse_req();
    chk("t3_erase_first_y", int'(vga_y), 116);
    repeat (15) tick();
    chk("t3_erase_last_y", int'(vga_y), 119);
    chk("t3_erase_last_x", int'(vga_x), 81);
    repeat (2) tick();
    chk("t3_draw_first_y", int'(vga_y), 0);
    chk("t3_draw_first_colour", int'(vga_colour), 6);
    chk("t3_coin_y_wrapped", int'(coin_y), 0);
    repeat (15) tick();
    chk("t3_draw_last_y", int'(vga_y), 3);
    tick();
    chk("t3_done", int'(done), 1);
    chk("t3_missed", int'(missed), 1);
    chk("t3_plot_in_done", int'(vga_plot), 0);
    tick();
    chk("t3_missed_pulse", int'(missed), 0);

    // Spawn clamp in IDLE, then spawn ignored while drawing
    do_reset();
    redraw();
    for (int i = 0; i < 6; i++) begin
      spawn   = 1'b1;
      spawn_x = stbl[i].sx;
      tick();
      spawn = 1'b0;
      chk($sformatf("t4_spawn_x_%0d", stbl[i].sx), int'(coin_x), int'(stbl[i].exp_x));
      chk($sformatf("t4_spawn_y_%0d", stbl[i].sx), int'(coin_y), 0);
    end
    pulse_req();
    repeat (19) tick();
    spawn   = 1'b1;
    spawn_x = 8'd10;
    tick();
    spawn = 1'b0;
    chk("t4_edge_x", int'(vga_x), 159);
    chk("t4_edge_y", int'(vga_y), 1);
    chk("t4_busy_spawn_x", int'(coin_x), 156);
    chk("t4_busy_spawn_y", int'(coin_y), 1);
    repeat (13) tick();
    chk("t4_done", int'(done), 1);
    tick();
    chk("t4_final_x", int'(coin_x), 156);

    // Spawn and plot_req together in IDLE
    do_reset();
    redraw();
    spawn    = 1'b1;
    spawn_x  = 8'd20;
    plot_req = 1'b1;
    tick();
    spawn    = 1'b0;
    plot_req = 1'b0;
    chk("t5_plot_T1", int'(vga_plot), 0);
    chk("t5_coin_x", int'(coin_x), 20);
    chk("t5_coin_y", int'(coin_y), 0);
    tick();
    chk("t5_plot_T2", int'(vga_plot), 1);
    chk("t5_x_T2", int'(vga_x), 20);
    chk("t5_y_T2", int'(vga_y), 0);
    chk("t5_colour_T2", int'(vga_colour), 0);
    repeat (33) tick();
    chk("t5_done", int'(done), 1);
    chk("t5_final_y", int'(coin_y), 1);

    // Asynchronous reset in the middle of DRAW with a request pending
    do_reset();
    pulse_req();
    repeat (4) tick();
    plot_req = 1'b1;
    tick();
    plot_req = 1'b0;
    repeat (19) tick();
    chk("t6_pre_plot", int'(vga_plot), 1);
    chk("t6_pre_x", int'(vga_x), 81);
    chk("t6_pre_y", int'(vga_y), 2);
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_plot", int'(vga_plot), 0);
    chk("t6_async_busy", int'(busy), 0);
    chk("t6_async_coin_y", int'(coin_y), 0);
    repeat (2) tick();
    resetn = 1'b1;
    plots = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      plots += int'(vga_plot);
    end
    chk("t6_no_writes", plots, 0);
    chk("t6_idle", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
